// File: rtl/sprite_plot_datapath.sv
`default_nettype none
// ============================================================================
// Module      : sprite_plot_datapath
// Description : Pixel-walking datapath for the game control FSM. Latches the
//               self and enemy sprite positions, issues one 5x5 sprite pixel
//               per plot cycle to the VGA adapter (registered, with clipping
//               and dead-enemy suppression), pulses self_done / enemy_done on
//               the last pixel of each pass and raises a sticky game_is_over
//               flag on a self/enemy overlap.
//               Optional feature macro: SPRITE_MASK_EN (applies SELF_MASK to
//               the self sprite shape).
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_plot_datapath #(
  parameter int          NUM_ENEMY    = 10,
  parameter logic [2:0]  SELF_COLOUR  = 3'b010,
  parameter logic [2:0]  ENEMY_COLOUR = 3'b100,
  parameter logic [2:0]  BG_COLOUR    = 3'b000,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [24:0] SELF_MASK    = 25'h1FFFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_coord,
  input  logic                   plot,
  input  logic                   datapath_select,
  input  logic [3:0]             self_state,
  input  logic [1:0]             enemy_op,
  input  logic [7:0]             self_x_in,
  input  logic [6:0]             self_y_in,
  input  logic [8*NUM_ENEMY-1:0] enemy_x_in,
  input  logic [7*NUM_ENEMY-1:0] enemy_y_in,
  input  logic [NUM_ENEMY-1:0]   enemy_alive_in,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   self_done,
  output logic                   enemy_done,
  output logic                   game_is_over
);

  localparam int               c_E_W      = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
  localparam logic [c_E_W-1:0] c_E_LAST   = c_E_W'(NUM_ENEMY - 1);
  localparam logic [4:0]       c_PIX_LAST = 5'd24;
  localparam logic [8:0]       c_SCREEN_W = 9'(SCREEN_W);
  localparam logic [8:0]       c_SCREEN_H = 9'(SCREEN_H);

  // Latched sprite state
  logic [7:0]           r_sx;
  logic [6:0]           r_sy;
  logic [7:0]           r_ex [NUM_ENEMY];
  logic [6:0]           r_ey [NUM_ENEMY];
  logic [NUM_ENEMY-1:0] r_alive;

  // Pass counters: r_p for self, r_e/r_q for enemy index / enemy pixel
  logic [4:0]       r_p;
  logic [4:0]       r_q;
  logic [c_E_W-1:0] r_e;
  logic             r_chk;

  logic [NUM_ENEMY-1:0] w_near;
  logic                 w_issue;
  logic [4:0]           w_cnt;
  logic [2:0]           w_col;
  logic [2:0]           w_row;
  logic [7:0]           w_base_x;
  logic [6:0]           w_base_y;
  logic [8:0]           w_x9;
  logic [8:0]           w_y9;
  logic                 w_on_screen;
  logic                 w_mask_bit;
  logic                 w_shape_ok;
  logic [2:0]           w_colour;
  logic                 w_self_last;
  logic                 w_enemy_last;
  logic [2:0]           w_unused_hi;

  // Latch the self coordinates and the alive vector on a load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_alive <= '0;
    end else if (load_coord) begin
      r_sx    <= self_x_in;
      r_sy    <= self_y_in;
      r_alive <= enemy_alive_in;
    end
  end

  // Per-enemy coordinate latch and overlap detector against the self sprite
  generate
    for (genvar gi = 0; gi < NUM_ENEMY; gi++) begin : g_enemy
      logic signed [8:0] w_dx;
      logic signed [7:0] w_dy;

      // Latch this enemy's position on a load
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ex[gi] <= '0;
          r_ey[gi] <= '0;
        end else if (load_coord) begin
          r_ex[gi] <= enemy_x_in[8*gi +: 8];
          r_ey[gi] <= enemy_y_in[7*gi +: 7];
        end
      end

      assign w_dx = $signed({1'b0, r_sx}) - $signed({1'b0, r_ex[gi]});
      assign w_dy = $signed({1'b0, r_sy}) - $signed({1'b0, r_ey[gi]});
      assign w_near[gi] = r_alive[gi] &&
                          (w_dx > -9'sd5) && (w_dx < 9'sd5) &&
                          (w_dy > -8'sd5) && (w_dy < 8'sd5);
    end
  endgenerate

  // Advance the counter of the active pass; a load restarts both passes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p <= '0;
      r_q <= '0;
      r_e <= '0;
    end else if (load_coord) begin
      r_p <= '0;
      r_q <= '0;
      r_e <= '0;
    end else if (plot) begin
      if (!datapath_select) begin
        r_p <= (r_p == c_PIX_LAST) ? 5'd0 : r_p + 5'd1;
      end else if (r_q == c_PIX_LAST) begin
        r_q <= 5'd0;
        r_e <= (r_e == c_E_LAST) ? '0 : r_e + 1'b1;
      end else begin
        r_q <= r_q + 5'd1;
      end
    end
  end

  // Current pixel: position within the 5x5 box, screen coordinates, colour
  assign w_issue     = plot & ~load_coord;
  assign w_cnt       = datapath_select ? r_q : r_p;
  assign w_col       = 3'(w_cnt % 5'd5);
  assign w_row       = 3'(w_cnt / 5'd5);
  assign w_base_x    = datapath_select ? r_ex[r_e] : r_sx;
  assign w_base_y    = datapath_select ? r_ey[r_e] : r_sy;
  assign w_x9        = {1'b0, w_base_x} + {6'd0, w_col};
  assign w_y9        = {2'b0, w_base_y} + {6'd0, w_row};
  assign w_on_screen = (w_x9 < c_SCREEN_W) && (w_y9 < c_SCREEN_H);
  assign w_unused_hi = {w_x9[8], w_y9[8:7]};

`ifdef SPRITE_MASK_EN
  assign w_mask_bit = SELF_MASK[r_p];
`else
  logic w_unused_mask;
  assign w_unused_mask = ^SELF_MASK;
  assign w_mask_bit    = 1'b1;
`endif

  assign w_shape_ok = datapath_select ? r_alive[r_e] : w_mask_bit;
  assign w_colour   = datapath_select ?
                      ((enemy_op == 2'b00)  ? ENEMY_COLOUR : BG_COLOUR) :
                      ((self_state == 4'd1) ? SELF_COLOUR  : BG_COLOUR);

  assign w_self_last  = w_issue & ~datapath_select & (r_p == c_PIX_LAST);
  assign w_enemy_last = w_issue &  datapath_select & (r_q == c_PIX_LAST) & (r_e == c_E_LAST);

  // Register the pixel write and the end-of-pass pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      self_done  <= 1'b0;
      enemy_done <= 1'b0;
    end else begin
      vga_plot   <= w_issue & w_on_screen & w_shape_ok;
      self_done  <= w_self_last;
      enemy_done <= w_enemy_last;
      if (w_issue) begin
        vga_x      <= w_x9[7:0];
        vga_y      <= w_y9[6:0];
        vga_colour <= w_colour;
      end
    end
  end

  // Collision check runs the cycle after a load; the flag never clears except by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chk        <= 1'b0;
      game_is_over <= 1'b0;
    end else begin
      r_chk <= load_coord;
      if (r_chk && (|w_near)) begin
        game_is_over <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sprite_plot_datapath.md
Name: sprite_plot_datapath

Overview:
- Datapath and responder for the game control FSM.
- Consumes the FSM's per-state controls: load_coord, plot, datapath_select, self_state, enemy_op.
- Walks the 5x5 self sprite and NUM_ENEMY 5x5 enemy sprites pixel by pixel. Drives the VGA adapter write port and returns self_done, enemy_done and game_is_over to the FSM.

Parameters:
- NUM_ENEMY, 10, number of enemy sprites; the enemy pass is NUM_ENEMY*25 pixels.
- SELF_COLOUR, 3'b010, self draw colour.
- ENEMY_COLOUR, 3'b100, enemy draw colour.
- BG_COLOUR, 3'b000, erase colour.
- SCREEN_W, 160, visible width; x >= SCREEN_W is clipped.
- SCREEN_H, 120, visible height; y >= SCREEN_H is clipped.
- SELF_MASK, 25'h1FFFFFF, self sprite shape, bit = row*5+col. Used only with SPRITE_MASK_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load_coord  in  1  latch all coordinates and alive bits this cycle
- plot  in  1  issue one pixel per cycle from the selected sprite set
- datapath_select  in  1  0 = self pass, 1 = enemy pass
- self_state  in  4  4'd1 = draw, 4'd2 = erase; any other value is treated as erase
- enemy_op  in  2  2'b00 = draw, 2'b01 = erase; other values are treated as erase
- self_x_in  in  8  self top-left x
- self_y_in  in  7  self top-left y
- enemy_x_in  in  8*NUM_ENEMY  packed enemy x; enemy i occupies bits [8i+7:8i]
- enemy_y_in  in  7*NUM_ENEMY  packed enemy y
- enemy_alive_in  in  NUM_ENEMY  alive bit per enemy
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable
- self_done  out  1  one-cycle pulse with the last self pixel
- enemy_done  out  1  one-cycle pulse with the last enemy pixel
- game_is_over  out  1  sticky collision flag

Behaviour:
- Reset: all outputs 0; latched coordinates, alive bits and counters 0; game_is_over cleared.
- Load: load_coord high latches self_x/y, all enemy_x/y and alive bits on the next edge. It also clears both pixel counters and has priority over plot in the same cycle.
- Self pass (plot=1, datapath_select=0):
  - 5-bit counter p runs 0..24; col = p mod 5, row = p div 5.
  - Pixel at (sx+col, sy+row).
  - Colour is SELF_COLOUR if self_state==1, else BG_COLOUR.
- Enemy pass (plot=1, datapath_select=1):
  - Enemy index e runs 0..NUM_ENEMY-1, with inner pixel counter q 0..24; e advances when q wraps.
  - Pixel at (ex[e]+col, ey[e]+row).
  - Colour is ENEMY_COLOUR if enemy_op==00, else BG_COLOUR.
- Counters advance only in plot cycles of their own pass. They hold when plot is low and wrap to 0 after the last pixel.
- Latency: pixel issued in cycle N appears registered on vga_x/vga_y/vga_colour/vga_plot in cycle N+1. vga_plot is low in cycles with no pixel.
- Done pulses, each registered and coincident with its last pixel's vga outputs:
  - self_done is high for exactly one cycle with pixel 24 of the self pass. Self pass length is 25 plot cycles.
  - enemy_done is high for one cycle with pixel 24 of enemy NUM_ENEMY-1. Enemy pass length is fixed at NUM_ENEMY*25 cycles.
- Dead enemies: pixels still consume cycles, but vga_plot = 0, so pass timing is independent of alive bits.
- Clipping: x+col and y+row are computed 9 bits wide. A pixel with sum >= SCREEN_W or >= SCREEN_H gets vga_plot = 0 and does not wrap. The cycle is still consumed.
- Collision: evaluated in the cycle after load_coord from the latched values.
  - game_is_over is set if any alive enemy satisfies |sx-ex|<5 and |sy-ey|<5.
  - The flag is sticky until reset and is never cleared by a later load.
- Select change: a change of datapath_select mid-pass does not clear the other pass's counter; each counter resumes where it stopped.
- Reset mid-pass: outputs drop to 0 asynchronously; no partial done pulse is emitted.

Optional Feature:
- Macro: SPRITE_MASK_EN.
- Defined: self pixels whose SELF_MASK bit is 0 get vga_plot = 0 (draw and erase alike); the cycle is still consumed and self_done timing is unchanged.
- Undefined: SELF_MASK is ignored and the self sprite is a solid 5x5 box.

Test Plan:
- Load self (10,20), self_state=1, plot 25 cycles -> 25 writes from (10,20) to (14,24), row-major, colour 3'b010; self_done high only on the (14,24) output cycle.
- Enemy pass, NUM_ENEMY=10, all alive, enemy_op=00 -> 250 writes, colour 3'b100; enemy_done high once at write 250; then enemy_op=01 -> same coordinates in 3'b000.
- Enemy 3 dead -> its 25 cycles have vga_plot=0; enemy_done still arrives at cycle 250.
- Self at (157,118) -> only x 157..159, y 118..119 written (6 pixels); self_done still at pixel 25.
- Self (50,50), enemy 0 at (54,46) -> game_is_over=1 one cycle after load. Enemy at (55,50) -> stays 0. A later non-overlapping load keeps it 1; reset clears it.
- plot dropped for 7 cycles after pixel 12 -> resumes at pixel 13, no duplicate or skipped pixel. Reset asserted mid-pass -> all outputs 0 immediately.
